req_ack_window_monitor: RTL and testbench
=========================================

REQ_ACK_WINDOW_MONITOR -- requirements
Module: req_ack_window_monitor

Interface
REQ-001 Parameter NCH, default 2: number of independent req/ack channels, legal range 1..32.
REQ-002 Parameter MIN_DLY, default 1: earliest legal ack cycle after req, legal range 1..MAX_DLY.
REQ-003 Parameter MAX_DLY, default 5: latest legal ack cycle after req, legal range MIN_DLY..255.
REQ-004 Parameter STRONG, default 1: 1 = strong semantics (a pending attempt at end-of-test fails), 0 = weak semantics (a pending attempt at end-of-test is discarded).
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req  input  NCH  per-channel request, sampled each edge.
REQ-008 ack  input  NCH  per-channel acknowledge, sampled each edge.
REQ-009 eot  input  1  end-of-test strobe, applies to all channels.
REQ-010 busy  output  NCH  channel has an attempt pending.
REQ-011 pass  output  NCH  one-cycle pulse, attempt matched in window.
REQ-012 fail_early  output  NCH  one-cycle pulse, ack before MIN_DLY.
REQ-013 fail_timeout  output  NCH  one-cycle pulse, no ack by MAX_DLY.
REQ-014 fail_eot  output  NCH  one-cycle pulse, strong attempt unfinished at eot.
REQ-015 any_fail  output  1  registered OR of all fail_* bits of the current cycle.
REQ-016 fail_cnt  output  16*NCH  per-channel failure counters, channel i at bits [16i+15:16i].

Function
REQ-017 Each channel SHALL be a two-state FSM, IDLE and WAIT, plus a delay counter of width clog2(MAX_DLY+1).
REQ-018 IDLE with req=1 at cycle t SHALL enter WAIT with count=1 at cycle t+1; ack in that same cycle t SHALL be ignored.
REQ-019 In WAIT with count=k, ack=1 and MIN_DLY<=k<=MAX_DLY SHALL return to IDLE and assert pass at the next edge.
REQ-020 In WAIT, ack=1 with k<MIN_DLY SHALL return to IDLE and assert fail_early at the next edge.
REQ-021 In WAIT, ack=0 with k==MAX_DLY SHALL return to IDLE and assert fail_timeout at the next edge.
REQ-022 Otherwise, in WAIT the count SHALL increment by 1; it SHALL never exceed MAX_DLY.
REQ-023 req while in WAIT SHALL be ignored (non-overlapping attempts), except in the resolving cycle of REQ-019..REQ-021, where req=1 SHALL start a new attempt (WAIT, count=1) instead of going to IDLE.
REQ-024 eot=1 SHALL force every channel to IDLE at the next edge; a channel in WAIT SHALL assert fail_eot if STRONG=1 and nothing if STRONG=0; eot SHALL take priority over REQ-019..REQ-023 in the same cycle, and req in the eot cycle SHALL be ignored.
REQ-025 busy SHALL equal the registered WAIT state (1 in the cycle after the starting req).
REQ-026 At most one of pass/fail_early/fail_timeout/fail_eot SHALL be 1 per channel per cycle; all SHALL be single-cycle pulses.
REQ-027 any_fail SHALL be asserted in the same cycle as the fail_* pulses it summarises (combinational OR of registered bits).
REQ-028 Channels SHALL be fully independent; eot and rst are the only shared controls.

Reset
REQ-029 rst=1 at an edge SHALL force all channels to IDLE, count=0, and busy, pass, fail_* and any_fail to 0 at that edge, aborting pending attempts without any fail pulse.
REQ-030 rst SHALL clear fail_cnt to 0; rst SHALL take priority over eot, req and ack.

Configuration
REQ-031 Macro REQ_ACK_MON_STATS_EN defined: each fail_cnt lane SHALL increment by 1 per fail_* pulse on its channel, saturating at 16'hFFFF.
REQ-032 Macro REQ_ACK_MON_STATS_EN undefined: fail_cnt SHALL be constant 0 and no counter logic SHALL be synthesised; all other behaviour SHALL be identical.

Verification (NCH=2, MIN_DLY=2, MAX_DLY=5, STRONG=1, stats enabled)
REQ-033 req0=1 at cycle 10, ack0=1 at cycle 13 -> busy0 1 on cycles 11..13, pass0 pulse at cycle 14, fail_cnt lane0 stays 0.
REQ-034 req0 at 10, ack0 at 11 -> fail_early0 and any_fail at 12, fail_cnt lane0=1; req0+ack0 both at 20 -> ack ignored, busy0=1 at 21.
REQ-035 req1 at 10, no ack1 -> fail_timeout1 at 16, busy1 0 at 16; req1 held 1 from 10 to 15 -> new attempt, busy1 stays 1 at 16.
REQ-036 req0 at 10, eot at 12 -> fail_eot0 at 13; repeat with STRONG=0 -> no pulse, busy0 0 at 13, fail_cnt unchanged.
REQ-037 req0 at 10, rst at 12 -> all outputs 0 at 13, no fail pulse, fail_cnt 0; 65536 timeouts on channel 1 -> lane1 saturates at 16'hFFFF, lane0 unaffected.

Source files
------------

// File: rtl/req_ack_window_monitor.sv
// req_ack_window_monitor
//   Per-channel request/acknowledge timing monitor. Each channel tracks one
//   attempt at a time: a req opens the attempt and the matching ack must
//   arrive between MIN_DLY and MAX_DLY cycles later. The result of each
//   attempt is reported as a one-cycle pulse.
//
//   Optional feature: define REQ_ACK_MON_STATS_EN to build saturating 16-bit
//   per-channel failure counters. Without it, fail_cnt is tied to 0.
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   req[NCH]      per-channel request
//   ack[NCH]      per-channel acknowledge
//   eot           end-of-test strobe, shared by all channels
//   busy[NCH]     attempt pending
//   pass[NCH]     pulse: ack arrived inside the window
//   fail_early    pulse: ack before MIN_DLY
//   fail_timeout  pulse: no ack by MAX_DLY
//   fail_eot      pulse: attempt still pending at eot (STRONG=1 only)
//   any_fail      OR of all fail_* pulses of this cycle
//   fail_cnt      per-channel failure counters, lane i at [16i+15:16i]
//
// state | meaning
// IDLE  | no attempt pending, waiting for req
// WAIT  | attempt pending, cnt = cycles since the starting req

module req_ack_window_monitor #(
    parameter int NCH     = 2,
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 5,
    parameter int STRONG  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     req,
    input  logic [NCH-1:0]     ack,
    input  logic               eot,
    output logic [NCH-1:0]     busy,
    output logic [NCH-1:0]     pass,
    output logic [NCH-1:0]     fail_early,
    output logic [NCH-1:0]     fail_timeout,
    output logic [NCH-1:0]     fail_eot,
    output logic               any_fail,
    output logic [16*NCH-1:0]  fail_cnt
);

    localparam int CW = $clog2(MAX_DLY + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [CW-1:0] MIN_K = CW'(MIN_DLY);
    localparam logic [CW-1:0] MAX_K = CW'(MAX_DLY);
    localparam logic [CW-1:0] ONE_K = CW'(1);

    logic [NCH-1:0]         state_q, state_d;
    logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]         pass_q, pass_d;
    logic [NCH-1:0]         fail_early_q, fail_early_d;
    logic [NCH-1:0]         fail_timeout_q, fail_timeout_d;
    logic [NCH-1:0]         fail_eot_q, fail_eot_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pass_d         = '0;
        fail_early_d   = '0;
        fail_timeout_d = '0;
        fail_eot_d     = '0;
        for (int i = 0; i < NCH; i++) begin
            if (eot) begin
                // eot overrides everything, including a req in the same cycle
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
                if (state_q[i] == ST_WAIT && STRONG != 0) begin
                    fail_eot_d[i] = 1'b1;
                end
            end else if (state_q[i] == ST_WAIT) begin
                if (ack[i] || cnt_q[i] == MAX_K) begin
                    if (ack[i]) begin
                        if (cnt_q[i] >= MIN_K) begin
                            pass_d[i] = 1'b1;
                        end else begin
                            fail_early_d[i] = 1'b1;
                        end
                    end else begin
                        fail_timeout_d[i] = 1'b1;
                    end
                    // a req in the resolving cycle chains straight into a new attempt
                    if (req[i]) begin
                        cnt_d[i] = ONE_K;
                    end else begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + ONE_K;
                end
            end else if (req[i]) begin
                // ack in the starting cycle is deliberately ignored
                state_d[i] = ST_WAIT;
                cnt_d[i]   = ONE_K;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= '0;
            cnt_q          <= '0;
            pass_q         <= '0;
            fail_early_q   <= '0;
            fail_timeout_q <= '0;
            fail_eot_q     <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pass_q         <= pass_d;
            fail_early_q   <= fail_early_d;
            fail_timeout_q <= fail_timeout_d;
            fail_eot_q     <= fail_eot_d;
        end
    end

    assign busy         = state_q;
    assign pass         = pass_q;
    assign fail_early   = fail_early_q;
    assign fail_timeout = fail_timeout_q;
    assign fail_eot     = fail_eot_q;
    assign any_fail     = |(fail_early_q | fail_timeout_q | fail_eot_q);

`ifdef REQ_ACK_MON_STATS_EN
    logic [16*NCH-1:0] fail_cnt_q, fail_cnt_d;
    logic [NCH-1:0]    fail_any_d;

    assign fail_any_d = fail_early_d | fail_timeout_d | fail_eot_d;

    // counters advance on the same edge that registers the fail pulse
    always_comb begin
        fail_cnt_d = fail_cnt_q;
        for (int i = 0; i < NCH; i++) begin
            if (fail_any_d[i] && fail_cnt_q[16*i +: 16] != 16'hFFFF) begin
                fail_cnt_d[16*i +: 16] = fail_cnt_q[16*i +: 16] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_cnt_q <= '0;
        end else begin
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign fail_cnt = fail_cnt_q;
`else
    assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_req_ack_window_monitor.sv
module tb_req_ack_window_monitor;

    localparam int MIN_D = 2;
    localparam int MAX_D = 5;

`ifdef REQ_ACK_MON_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  ack = '0;
    logic        eot = 1'b0;

    logic [1:0]  m_busy, m_pass, m_fail_early, m_fail_timeout, m_fail_eot;
    logic        m_any_fail;
    logic [31:0] m_fail_cnt;
    logic [1:0]  w_busy, w_pass, w_fail_early, w_fail_timeout, w_fail_eot;
    logic        w_any_fail;
    logic [31:0] w_fail_cnt;

    logic        rst_s = 1'b1;
    logic [1:0]  req_s = '0;
    logic [1:0]  s_busy, s_pass, s_fail_early, s_fail_timeout, s_fail_eot;
    logic        s_any_fail;
    logic [31:0] s_fail_cnt;

    always #5 clk = ~clk;

    req_ack_window_monitor #(.NCH(2), .MIN_DLY(MIN_D), .MAX_DLY(MAX_D), .STRONG(1)) dut_m (
        .clk(clk), .rst(rst), .req(req), .ack(ack), .eot(eot),
        .busy(m_busy), .pass(m_pass), .fail_early(m_fail_early),
        .fail_timeout(m_fail_timeout), .fail_eot(m_fail_eot),
        .any_fail(m_any_fail), .fail_cnt(m_fail_cnt));

    req_ack_window_monitor #(.NCH(2), .MIN_DLY(MIN_D), .MAX_DLY(MAX_D), .STRONG(0)) dut_w (
        .clk(clk), .rst(rst), .req(req), .ack(ack), .eot(eot),
        .busy(w_busy), .pass(w_pass), .fail_early(w_fail_early),
        .fail_timeout(w_fail_timeout), .fail_eot(w_fail_eot),
        .any_fail(w_any_fail), .fail_cnt(w_fail_cnt));

    // one timeout per cycle with req held, to reach counter saturation quickly
    req_ack_window_monitor #(.NCH(2), .MIN_DLY(1), .MAX_DLY(1), .STRONG(1)) dut_s (
        .clk(clk), .rst(rst_s), .req(req_s), .ack(2'b00), .eot(1'b0),
        .busy(s_busy), .pass(s_pass), .fail_early(s_fail_early),
        .fail_timeout(s_fail_timeout), .fail_eot(s_fail_eot),
        .any_fail(s_any_fail), .fail_cnt(s_fail_cnt));

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: attempts tracked by start timestamp; m=0 strong, m=1 weak.
    int       cyc = 0;
    bit       pend  [2][2];
    int       start [2][2];
    int       fcnt  [2][2];
    bit [1:0] e_busy[2], e_pass[2], e_early[2], e_to[2], e_eot[2];

    task automatic model_edge();
        int age;
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 2; c++) begin
                e_pass[m][c]  = 1'b0;
                e_early[m][c] = 1'b0;
                e_to[m][c]    = 1'b0;
                e_eot[m][c]   = 1'b0;
                if (rst) begin
                    pend[m][c] = 1'b0;
                    fcnt[m][c] = 0;
                end else begin
                    if (eot) begin
                        if (pend[m][c] && m == 0) e_eot[m][c] = 1'b1;
                        pend[m][c] = 1'b0;
                    end else if (pend[m][c]) begin
                        age = cyc - start[m][c];
                        if (ack[c] || age == MAX_D) begin
                            if (!ack[c])          e_to[m][c]    = 1'b1;
                            else if (age < MIN_D) e_early[m][c] = 1'b1;
                            else                  e_pass[m][c]  = 1'b1;
                            pend[m][c] = req[c];
                            start[m][c] = cyc;
                        end
                    end else if (req[c]) begin
                        pend[m][c]  = 1'b1;
                        start[m][c] = cyc;
                    end
                    if ((e_early[m][c] | e_to[m][c] | e_eot[m][c]) && fcnt[m][c] < 65535)
                        fcnt[m][c]++;
                end
                e_busy[m][c] = pend[m][c];
            end
        end
    endtask

    function automatic logic [63:0] exp_vec(input int m);
        logic [15:0] c0, c1;
        c0 = STATS ? 16'(fcnt[m][0]) : 16'h0;
        c1 = STATS ? 16'(fcnt[m][1]) : 16'h0;
        return 64'({e_busy[m], e_pass[m], e_early[m], e_to[m], e_eot[m],
                    |(e_early[m] | e_to[m] | e_eot[m]), c1, c0});
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        chk($sformatf("strong@%0d", cyc),
            64'({m_busy, m_pass, m_fail_early, m_fail_timeout, m_fail_eot, m_any_fail, m_fail_cnt}),
            exp_vec(0));
        chk($sformatf("weak@%0d", cyc),
            64'({w_busy, w_pass, w_fail_early, w_fail_timeout, w_fail_eot, w_any_fail, w_fail_cnt}),
            exp_vec(1));
    endtask

    typedef struct {
        bit rst, eot, req, ack;
        bit b, p, fe, ft, fo;
    } vec_t;

    vec_t tv[$];

    initial begin
        // inputs for one cycle on channel 0 | channel 0 outputs after that edge
        tv.push_back('{1,0,0,0, 0,0,0,0,0});
        // pass at k=3
        tv.push_back('{0,0,1,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,1, 0,1,0,0,0});
        tv.push_back('{0,0,0,0, 0,0,0,0,0});
        // early at k=1
        tv.push_back('{0,0,1,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,1, 0,0,1,0,0});
        tv.push_back('{0,0,0,0, 0,0,0,0,0});
        // req+ack together: ack ignored, then pass at k=2 (MIN edge)
        tv.push_back('{0,0,1,1, 1,0,0,0,0});
        tv.push_back('{0,0,0,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,1, 0,1,0,0,0});
        // eot while pending
        tv.push_back('{0,0,1,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,0, 1,0,0,0,0});
        tv.push_back('{0,1,0,0, 0,0,0,0,1});
        // req during eot is ignored
        tv.push_back('{0,1,1,0, 0,0,0,0,0});
        // pass at k=5 (MAX edge)
        tv.push_back('{0,0,1,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,1, 0,1,0,0,0});
        // timeout with req in resolving cycle chains a new attempt
        tv.push_back('{0,0,1,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,0, 1,0,0,0,0});
        tv.push_back('{0,0,1,0, 1,0,0,1,0});
        tv.push_back('{0,0,0,1, 0,0,1,0,0});
        // plain timeout
        tv.push_back('{0,0,1,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,0, 0,0,0,1,0});
        // reset mid-attempt aborts silently
        tv.push_back('{0,0,1,0, 1,0,0,0,0});
        tv.push_back('{0,0,0,0, 1,0,0,0,0});
        tv.push_back('{1,0,0,0, 0,0,0,0,0});

        for (int i = 0; i < tv.size(); i++) begin
            rst = tv[i].rst;
            eot = tv[i].eot;
            req = {1'b0, tv[i].req};
            ack = {1'b0, tv[i].ack};
            tick();
            chk($sformatf("tbl[%0d]", i),
                64'({m_busy[0], m_pass[0], m_fail_early[0], m_fail_timeout[0], m_fail_eot[0]}),
                64'({tv[i].b, tv[i].p, tv[i].fe, tv[i].ft, tv[i].fo}));
        end
        chk("rst_any_fail", 64'(m_any_fail), 64'(0));
        chk("rst_fail_cnt", 64'(m_fail_cnt), 64'(0));

        // weak semantics: eot on a pending attempt is silent
        rst = 1'b0; eot = 1'b0; ack = '0;
        req = 2'b01; tick();
        req = 2'b00; tick();
        eot = 1'b1;  tick();
        eot = 1'b0;
        chk("weak_eot_pulse", 64'(w_fail_eot), 64'(0));
        chk("weak_eot_busy",  64'(w_busy),     64'(0));
        chk("weak_eot_cnt",   64'(w_fail_cnt), 64'(0));
        chk("strong_eot_pulse", 64'(m_fail_eot), 64'(2'b01));

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            eot = ($urandom_range(0, 39) == 0);
            req = 2'($urandom_range(0, 3)) & {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            ack = 2'($urandom_range(0, 3)) & {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            tick();
        end
        rst = 1'b0; eot = 1'b0; req = '0; ack = '0;

        // saturation on a MIN=MAX=1 instance
        @(posedge clk); #1;
        chk("sat_reset_cnt", 64'(s_fail_cnt), 64'(0));
        rst_s = 1'b0;
        req_s = 2'b10;
        repeat (100) @(posedge clk);
        #1;
        chk("sat_cnt_99", 64'(s_fail_cnt), STATS ? 64'({16'd99, 16'd0}) : 64'(0));
        chk("sat_any_fail", 64'(s_any_fail), 64'(1));
        chk("sat_busy", 64'(s_busy), 64'(2'b10));
        repeat (65440) @(posedge clk);
        #1;
        chk("sat_lane1", 64'(s_fail_cnt[31:16]), STATS ? 64'(16'hFFFF) : 64'(0));
        chk("sat_lane0", 64'(s_fail_cnt[15:0]), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
